mem_subsystem: RTL and testbench

MEM_SUBSYSTEM -- requirements
Module: mem_subsystem

---
 rtl/mem_if.sv | 24 ++
 rtl/mem_subsystem.sv | 131 +++++++++++++
 tb/tb_mem_subsystem.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// CPU-side request/response bus of the memory subsystem.
// Request: a transfer happens on a rising edge where req_valid && req_ready; rsp_valid pulses one cycle after an accepted read.
interface mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_subsystem.sv
// Word RAM plus memory-mapped I/O ports, each with an RX and a TX FIFO.
// MMIO port p: DATA at MMIO_BASE+2p (pop RX / push TX), STATUS at MMIO_BASE+2p+1.
module mem_subsystem #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RAM_DEPTH  = 4096,
    parameter int MMIO_BASE  = 'hFF00,
    parameter int PORT_COUNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mem_if.slave                         bus,
    output logic [PORT_COUNT-1:0]        port_tx_valid,
    input  logic [PORT_COUNT-1:0]        port_tx_ready,
    output logic [PORT_COUNT*DATA_W-1:0] port_tx_data,
    input  logic [PORT_COUNT-1:0]        port_rx_valid,
    output logic [PORT_COUNT-1:0]        port_rx_ready,
    input  logic [PORT_COUNT*DATA_W-1:0] port_rx_data
);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int PIW    = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    localparam logic [ADDR_W:0]   RAM_LIM = RAM_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] MB      = MMIO_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W-2:0] PC_L    = PORT_COUNT[ADDR_W-2:0];
    localparam logic [CW-1:0]     DEPTH_C = FIFO_DEPTH[CW-1:0];

    logic [DATA_W-1:0] ram    [RAM_DEPTH];
    logic [DATA_W-1:0] tx_mem [PORT_COUNT][FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [PORT_COUNT][FIFO_DEPTH];

    logic [PW-1:0] tx_wr [PORT_COUNT];
    logic [PW-1:0] tx_rd [PORT_COUNT];
    logic [CW-1:0] tx_count [PORT_COUNT];
    logic [PW-1:0] rx_wr [PORT_COUNT];
    logic [PW-1:0] rx_rd [PORT_COUNT];
    logic [CW-1:0] rx_count [PORT_COUNT];

    logic [PORT_COUNT-1:0] tx_push, tx_pop, rx_push, rx_pop, tx_full;

    logic              in_ram, in_mmio, mmio_ok, is_data;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-2:0] port_idx;
    logic [PIW-1:0]    sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              acc, acc_rd, acc_wr;
    logic [DATA_W-1:0] rd_val, status;

    // Address decode
    assign in_ram   = {1'b0, bus.req_addr} < RAM_LIM;
    assign in_mmio  = bus.req_addr >= MB;
    assign off      = bus.req_addr - MB;
    assign port_idx = off[ADDR_W-1:1];
    assign is_data  = ~off[0];
    assign mmio_ok  = in_mmio && (port_idx < PC_L);
    assign sel      = port_idx[PIW-1:0];
    assign ram_idx  = bus.req_addr[RAM_AW-1:0];

    // Backpressure only depends on registered TX counts, never on port_tx_ready.
    assign bus.req_ready = !(bus.req_valid && bus.req_write && mmio_ok && is_data && tx_full[sel]);
    assign acc    = bus.req_valid && bus.req_ready;
    assign acc_rd = acc && !bus.req_write;
    assign acc_wr = acc && bus.req_write;

    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            tx_full[p]       = (tx_count[p] == DEPTH_C);
            tx_pop[p]        = (tx_count[p] != '0) && port_tx_ready[p];
            tx_push[p]       = acc_wr && mmio_ok && is_data && (sel == PIW'(p));
            rx_push[p]       = port_rx_valid[p] && (rx_count[p] != DEPTH_C);
            rx_pop[p]        = acc_rd && mmio_ok && is_data && (sel == PIW'(p)) && (rx_count[p] != '0);
            port_tx_valid[p] = (tx_count[p] != '0);
            port_rx_ready[p] = (rx_count[p] != DEPTH_C);
            port_tx_data[p*DATA_W +: DATA_W] = tx_mem[p][tx_rd[p]];
        end
    end

    always_comb begin
        status       = '0;
        status[0]    = (rx_count[sel] != '0);
        status[1]    = (tx_count[sel] != DEPTH_C);
        status[8 +: CW] = rx_count[sel];
        rd_val       = '0;
        if (in_ram) begin
            rd_val = ram[ram_idx];
        end else if (mmio_ok) begin
            if (!is_data) rd_val = status;
            else if (rx_count[sel] != '0) rd_val = rx_mem[sel][rx_rd[sel]];
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (acc_wr && in_ram) ram[ram_idx] <= bus.req_wdata;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (tx_push[p]) tx_mem[p][tx_wr[p]] <= bus.req_wdata;
            if (rx_push[p]) rx_mem[p][rx_wr[p]] <= port_rx_data[p*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                tx_wr[p]    <= '0;
                tx_rd[p]    <= '0;
                tx_count[p] <= '0;
                rx_wr[p]    <= '0;
                rx_rd[p]    <= '0;
                rx_count[p] <= '0;
            end
        end else begin
            bus.rsp_valid <= acc_rd;
            bus.rsp_rdata <= acc_rd ? rd_val : '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (tx_push[p]) tx_wr[p] <= tx_wr[p] + 1'b1;
                if (tx_pop[p])  tx_rd[p] <= tx_rd[p] + 1'b1;
                if (tx_push[p] && !tx_pop[p])      tx_count[p] <= tx_count[p] + 1'b1;
                else if (!tx_push[p] && tx_pop[p]) tx_count[p] <= tx_count[p] - 1'b1;
                if (rx_push[p]) rx_wr[p] <= rx_wr[p] + 1'b1;
                if (rx_pop[p])  rx_rd[p] <= rx_rd[p] + 1'b1;
                if (rx_push[p] && !rx_pop[p])      rx_count[p] <= rx_count[p] + 1'b1;
                else if (!rx_push[p] && rx_pop[p]) rx_count[p] <= rx_count[p] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem: RAM, TX backpressure, RX pop/status, unmapped access, reset flush.
module tb_mem_subsystem;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int PC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PC-1:0]    port_tx_valid, port_tx_ready, port_rx_valid, port_rx_ready;
  logic [PC*DW-1:0] port_tx_data, port_rx_data;

  int total = 0;
  int bad = 0;

  mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_subsystem #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(4096), .MMIO_BASE('hFF00),
                  .PORT_COUNT(PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .port_tx_valid(port_tx_valid), .port_tx_ready(port_tx_ready), .port_tx_data(port_tx_data),
    .port_rx_valid(port_rx_valid), .port_rx_ready(port_rx_ready), .port_rx_data(port_rx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask

  // Read issued now, response checked the next cycle, and its removal the cycle after.
  task automatic cpu_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_rv"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rd"}, 32'(bus.rsp_rdata), 32'(exp));
    tick();
    chk({tag, "_rv0"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rd0"}, 32'(bus.rsp_rdata), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    port_tx_ready = '0;
    port_rx_valid = '0;
    port_rx_data  = '0;

    // Reset values
    #12;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_tx_valid", 32'(port_tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(port_rx_ready), 32'hF);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // RAM write then read on the very next cycle
    cpu_wr(16'h0010, 16'h1234);
    chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    cpu_rd("ram_raw", 16'h0010, 16'h1234);
    cpu_wr(16'h0FFF, 16'hBEEF);
    cpu_rd("ram_top", 16'h0FFF, 16'hBEEF);
    cpu_rd("unmap_1000", 16'h1000, 16'h0000);

    // Unmapped and discarded writes leave no trace
    cpu_wr(16'h8000, 16'hDEAD);
    cpu_wr(16'hFF01, 16'hDEAD);
    cpu_wr(16'hFF08, 16'hDEAD);
    tick();
    chk("unmap_wr_tx", 32'(port_tx_valid), 32'h0);
    cpu_rd("unmap_wr_ram", 16'h0010, 16'h1234);
    cpu_rd("unmap_8000", 16'h8000, 16'h0000);

    // TX backpressure on port 0
    for (int i = 1; i <= 4; i++) begin
      chk("tx_fill_ready", 32'(bus.req_ready), 32'd1);
      cpu_wr(16'hFF00, 16'(i));
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'hFF00;
    bus.req_wdata = 16'h0005;
    #1;
    chk("tx_full_ready", 32'(bus.req_ready), 32'd0);
    chk("tx_full_head", 32'(port_tx_data[15:0]), 32'h1);
    tick();
    chk("tx_stall_ready", 32'(bus.req_ready), 32'd0);
    port_tx_ready[0] = 1'b1;
    #1;
    chk("tx_no_comb_path", 32'(bus.req_ready), 32'd0);
    tick();
    port_tx_ready[0] = 1'b0;
    chk("tx_after_pop_ready", 32'(bus.req_ready), 32'd1);
    chk("tx_after_pop_head", 32'(port_tx_data[15:0]), 32'h2);
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    port_tx_ready[0] = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("tx_drain_valid", 32'(port_tx_valid[0]), 32'd1);
      chk("tx_drain_data", 32'(port_tx_data[15:0]), 32'(i));
      tick();
    end
    chk("tx_empty", 32'(port_tx_valid), 32'h0);
    port_tx_ready[0] = 1'b0;

    // RX on port 1
    port_rx_valid[1] = 1'b1;
    port_rx_data[31:16] = 16'hAAAA;
    tick();
    port_rx_data[31:16] = 16'h5555;
    tick();
    port_rx_valid[1] = 1'b0;
    cpu_rd("rx_status2", 16'hFF03, 16'h0203);
    cpu_rd("rx_pop_a", 16'hFF02, 16'hAAAA);
    cpu_rd("rx_pop_5", 16'hFF02, 16'h5555);
    cpu_rd("rx_empty", 16'hFF02, 16'h0000);
    cpu_rd("rx_status0", 16'hFF03, 16'h0002);

    // RX full on port 2 with simultaneous pop and offered word
    port_rx_valid[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      port_rx_data[47:32] = 16'(i * 16'h11);
      tick();
    end
    chk("rx_full_ready", 32'(port_rx_ready[2]), 32'd0);
    port_rx_data[47:32] = 16'h0099;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'hFF04;
    tick();
    bus.req_valid = 1'b0;
    port_rx_valid[2] = 1'b0;
    chk("rx_full_pop", 32'(bus.rsp_rdata), 32'h0011);
    chk("rx_ready_back", 32'(port_rx_ready[2]), 32'd1);
    tick();
    cpu_rd("rx_status3", 16'hFF05, 16'h0303);
    cpu_rd("rx_pop_22", 16'hFF04, 16'h0022);
    cpu_rd("rx_pop_33", 16'hFF04, 16'h0033);
    cpu_rd("rx_pop_44", 16'hFF04, 16'h0044);
    cpu_rd("rx_no_99", 16'hFF04, 16'h0000);

    // Port PORT_COUNT is unmapped
    cpu_rd("port4_data", 16'hFF08, 16'h0000);
    cpu_rd("port4_stat", 16'hFF09, 16'h0000);

    // Reset with TX words queued and a read response in flight
    for (int i = 0; i < 3; i++) cpu_wr(16'hFF06, 16'(16'h0100 + i));
    chk("pre_rst_tx3", 32'(port_tx_valid[3]), 32'd1);
    cpu_rd("pre_rst_stat", 16'hFF07, 16'h0002);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'hFF00;
    tick();
    bus.req_valid = 1'b0;
    chk("inflight_rv", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rd", 32'(bus.rsp_rdata), 32'd0);
    chk("mid_rst_txv", 32'(port_tx_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    cpu_rd("post_rst_stat", 16'hFF07, 16'h0002);
    chk("post_rst_txv", 32'(port_tx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
